// File: rtl/cardinal_lsu_pkg.sv
// Shared types and constants for the cardinal load/store unit.
package cardinal_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } lsu_state_e;

  localparam int CH_DMEM = 0;
  localparam int CH_NIC  = 3;

  // Wait counter holds 0..timeout-1.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout <= 1) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/cardinal_lsu_decode.sv
// Channel decode: top address bits -> one-hot channel select plus valid flag.
module cardinal_lsu_decode #(
  parameter int SEL_W  = 2,
  parameter int NUM_CH = 4
) (
  input  logic [SEL_W-1:0]  idx,
  output logic [NUM_CH-1:0] sel_oh,
  output logic              idx_valid
);

  // One-hot select; an index beyond the populated channels selects nothing.
  always_comb begin
    idx_valid = (32'(idx) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = (32'(idx) == i);
    end
  end

endmodule

// File: rtl/cardinal_lsu.sv
// Load/store unit fanning EXMEM requests out to NUM_CH ready-handshaked targets.
// Optional CARDINAL_LSU_STATS_EN adds saturating stall-cycle and error counters.
module cardinal_lsu
  import cardinal_lsu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16,
  parameter int SEL_W   = 2,
  parameter int NUM_CH  = 4,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [RD_W-1:0]          req_rd,
  output logic                     lsu_stall,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic [RD_W-1:0]          resp_rd,
  output logic                     wr_done,
  output logic                     err,
  output logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        ch_wr_en,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ready
`ifdef CARDINAL_LSU_STATS_EN
  ,
  output logic [31:0]              stat_stall_cycles,
  output logic [15:0]              stat_errors
`endif
);

  localparam int CNT_W = timeout_cnt_w(TIMEOUT);

  lsu_state_e        state_q, state_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic              we_q, we_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d, ch_wr_en_q, ch_wr_en_d;
  logic [ADDR_W-1:0] ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0] ch_wdata_q, ch_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
  logic              wr_done_q, wr_done_d, err_q, err_d, stall_q, stall_d;

  logic [NUM_CH-1:0] dec_oh_s;
  logic              dec_valid_s;
  logic              ready_hit_s;
  logic [DATA_W-1:0] rdata_sel_s;

  cardinal_lsu_decode #(
    .SEL_W  (SEL_W),
    .NUM_CH (NUM_CH)
  ) u_decode (
    .idx       (req_addr[ADDR_W-1 -: SEL_W]),
    .sel_oh    (dec_oh_s),
    .idx_valid (dec_valid_s)
  );

  // Handshake and read-data selection for the latched channel.
  always_comb begin
    ready_hit_s = |(ch_ready & sel_q);
    rdata_sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rdata_sel_s = rdata_sel_s | ({DATA_W{sel_q[i]}} & ch_rdata[i*DATA_W +: DATA_W]);
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    we_d         = we_q;
    rd_d         = rd_q;
    wait_d       = wait_q;
    ch_en_d      = ch_en_q;
    ch_wr_en_d   = ch_wr_en_q;
    ch_addr_d    = ch_addr_q;
    ch_wdata_d   = ch_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    wr_done_d    = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ch_addr_d  = req_addr;
          ch_wdata_d = req_wdata;
          we_d       = req_we;
          rd_d       = req_rd;
          sel_d      = dec_oh_s;
          wait_d     = '0;
          if (dec_valid_s) begin
            state_d    = REQ;
            ch_en_d    = dec_oh_s;
            ch_wr_en_d = {NUM_CH{req_we}} & dec_oh_s;
          end else begin
            // Unmapped address: answer at once, never touch a channel.
            err_d        = 1'b1;
            resp_valid_d = ~req_we;
            resp_data_d  = '0;
            resp_rd_d    = req_rd;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ready_hit_s) begin
          ch_en_d    = '0;
          ch_wr_en_d = '0;
          wait_d     = '0;
          if (we_q) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          ch_en_d      = '0;
          ch_wr_en_d   = '0;
          wait_d       = '0;
          err_d        = 1'b1;
          resp_valid_d = ~we_q;
          resp_data_d  = '0;
          resp_rd_d    = rd_q;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      DATA: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_data_d  = rdata_sel_s;
        resp_rd_d    = rd_q;
      end
      default: begin
        state_d    = IDLE;
        ch_en_d    = '0;
        ch_wr_en_d = '0;
      end
    endcase
    stall_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      wait_q       <= '0;
      ch_en_q      <= '0;
      ch_wr_en_q   <= '0;
      ch_addr_q    <= '0;
      ch_wdata_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      wr_done_q    <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      wait_q       <= wait_d;
      ch_en_q      <= ch_en_d;
      ch_wr_en_q   <= ch_wr_en_d;
      ch_addr_q    <= ch_addr_d;
      ch_wdata_q   <= ch_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      wr_done_q    <= wr_done_d;
      err_q        <= err_d;
      stall_q      <= stall_d;
    end
  end

  assign lsu_stall  = stall_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign wr_done    = wr_done_q;
  assign err        = err_q;
  assign ch_en      = ch_en_q;
  assign ch_wr_en   = ch_wr_en_q;
  assign ch_addr    = ch_addr_q;
  assign ch_wdata   = ch_wdata_q;

`ifdef CARDINAL_LSU_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating event counters.
  always_comb begin
    if (stall_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_errors       = err_cnt_q;
`endif

endmodule

// File: tb/tb_cardinal_lsu.sv
// Randomized bench for cardinal_lsu against a transaction-level timing/data model.
module tb_cardinal_lsu;

  localparam int DW  = 64;
  localparam int AW  = 16;
  localparam int SW  = 3;
  localparam int NCH = 6;
  localparam int RW  = 5;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [RW-1:0] req_rd;
  logic lsu_stall, resp_valid, wr_done, err;
  logic [DW-1:0] resp_data;
  logic [RW-1:0] resp_rd;
  logic [NCH-1:0] ch_en, ch_wr_en, ch_ready;
  logic [AW-1:0] ch_addr;
  logic [DW-1:0] ch_wdata;
  logic [NCH*DW-1:0] ch_rdata;
`ifdef CARDINAL_LSU_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [15:0] stat_errors;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_stall_cnt = 0;
  int exp_err_cnt = 0;

  always #5 clk = ~clk;

  cardinal_lsu #(
    .DATA_W (DW), .ADDR_W (AW), .SEL_W (SW), .NUM_CH (NCH), .RD_W (RW), .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .lsu_stall  (lsu_stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .wr_done    (wr_done),
    .err        (err),
    .ch_en      (ch_en),
    .ch_wr_en   (ch_wr_en),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_rdata   (ch_rdata),
    .ch_ready   (ch_ready)
`ifdef CARDINAL_LSU_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_errors       (stat_errors)
`endif
  );

  // Target stubs: 1-cycle-latency memories, one per channel.
  logic [DW-1:0] stub_mem [2048];
  logic [DW-1:0] ref_mem  [2048];
  logic [DW-1:0] rdata_r  [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_rdata
    assign ch_rdata[g*DW +: DW] = rdata_r[g];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ch_en[i] && ch_ready[i]) begin
        if (ch_wr_en[i]) stub_mem[{3'(i), ch_addr[7:0]}] <= ch_wdata;
        else rdata_r[i] <= stub_mem[{3'(i), ch_addr[7:0]}];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transaction; entered and left at a negedge. d = REQ cycles with ready low.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [RW-1:0] rd, input int d);
    int idx, n_en, strobe;
    bit ok, e_err, e_rv, e_wd;
    logic [DW-1:0] e_data;
    logic [NCH-1:0] oh;
    logic [10:0] key;
    idx = int'(addr[AW-1 -: SW]);
    ok = (idx < NCH);
    oh = ok ? (NCH'(1) << idx) : '0;
    key = {addr[AW-1 -: SW], addr[7:0]};
    e_data = '0; e_err = 1'b0; e_rv = ~we; e_wd = 1'b0;
    if (!ok) begin
      n_en = 0; strobe = 1; e_err = 1'b1;
    end else if (d < TO) begin
      n_en = d + 1;
      strobe = we ? d + 2 : d + 3;
      e_wd = we;
      if (we) ref_mem[key] = wd;
      else e_data = ref_mem[key];
    end else begin
      n_en = TO; strobe = TO + 1; e_err = 1'b1;
    end
    exp_stall_cnt += strobe - 1;
    exp_err_cnt += int'(e_err);

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_rd = rd;
    ch_ready = NCH'($urandom);
    for (int c = 1; c <= strobe; c++) begin
      @(negedge clk);
      chk("stall", 64'(lsu_stall), 64'(c < strobe));
      chk("ch_en", 64'(ch_en), (c <= n_en) ? 64'(oh) : 64'd0);
      chk("ch_wr_en", 64'(ch_wr_en), (c <= n_en && we) ? 64'(oh) : 64'd0);
      if (c <= n_en) chk("ch_addr", 64'(ch_addr), 64'(addr));
      if (c <= n_en && we) chk("ch_wdata", ch_wdata, wd);
      chk("resp_valid", 64'(resp_valid), 64'(c == strobe && e_rv));
      chk("wr_done", 64'(wr_done), 64'(c == strobe && e_wd));
      chk("err", 64'(err), 64'(c == strobe && e_err));
      if (c == strobe && e_rv) begin
        chk("resp_data", resp_data, e_data);
        chk("resp_rd", 64'(resp_rd), 64'(rd));
      end
      if (c < strobe) begin
        // Requests during a stall must be ignored; drive junk.
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = {$urandom, $urandom}; req_rd = RW'($urandom);
        ch_ready = NCH'($urandom);
        if (ok && c <= n_en) ch_ready[idx] = (c > d);
      end
    end
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_stall", 64'(lsu_stall), 64'd0);
  endtask

  initial begin
    logic [2:0] ridx;
    int r, dd;
    for (int i = 0; i < 2048; i++) begin
      stub_mem[i] = {21'h1A5A5, 11'(i), 21'h0F0F0, 11'(i)};
      ref_mem[i]  = {21'h1A5A5, 11'(i), 21'h0F0F0, 11'(i)};
    end
    for (int i = 0; i < NCH; i++) rdata_r[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    ch_ready = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", 64'(lsu_stall), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_rd", 64'(resp_rd), 64'd0);
    chk("rst_wr_done", 64'(wr_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ch_en", 64'(ch_en), 64'd0);
    chk("rst_ch_wr_en", 64'(ch_wr_en), 64'd0);
    chk("rst_ch_addr", 64'(ch_addr), 64'd0);
    chk("rst_ch_wdata", ch_wdata, 64'd0);
    rst = 1'b0;

    // Directed: dmem store/load, slow NIC store, decode errors, timeouts, back-to-back.
    run_txn(1'b1, 16'h0010, 64'hDEADBEEF_00000001, 5'd0, 0);
    idle_cycle();
    run_txn(1'b0, 16'h0010, 64'd0, 5'd7, 0);
    idle_cycle();
    run_txn(1'b1, 16'h6001, 64'h55, 5'd0, 4);
    idle_cycle();
    run_txn(1'b0, 16'hE000, 64'd0, 5'd3, 0);
    run_txn(1'b1, 16'hC000, 64'h77, 5'd0, 0);
    idle_cycle();
    run_txn(1'b0, 16'h0010, 64'd0, 5'd9, TO);
    run_txn(1'b1, 16'h2020, 64'h1234, 5'd0, TO + 2);
    run_txn(1'b0, 16'h6001, 64'd0, 5'd11, TO - 1);
    run_txn(1'b0, 16'h0010, 64'd0, 5'd12, 1);
    run_txn(1'b0, 16'h2020, 64'd0, 5'd13, 0);

    // Random traffic with random back-to-back issue.
    for (int n = 0; n < 300; n++) begin
      ridx = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      dd = (r < 6) ? $urandom_range(0, 2) : (r < 8) ? $urandom_range(3, TO - 1)
                                                    : $urandom_range(TO, TO + 2);
      run_txn(1'($urandom), {ridx, 5'd0, 8'($urandom_range(0, 15))}, {$urandom, $urandom},
              RW'($urandom), dd);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

`ifdef CARDINAL_LSU_STATS_EN
    idle_cycle();
    chk("stat_stall", 64'(stat_stall_cycles), 64'(exp_stall_cnt));
    chk("stat_errors", 64'(stat_errors), 64'(exp_err_cnt));
`endif

    // Asynchronous reset while a load waits in REQ.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h2008; req_rd = 5'd5; ch_ready = '0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ch_en", 64'(ch_en), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ch_en", 64'(ch_en), 64'd0);
    chk("async_rst_stall", 64'(lsu_stall), 64'd0);
    ch_ready = '1;
    @(negedge clk);
    rst = 1'b0;
    exp_stall_cnt = 0;
    exp_err_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("post_rst_wr_done", 64'(wr_done), 64'd0);
      chk("post_rst_ch_en", 64'(ch_en), 64'd0);
    end
`ifdef CARDINAL_LSU_STATS_EN
    chk("post_rst_stat_stall", 64'(stat_stall_cycles), 64'd0);
    chk("post_rst_stat_errors", 64'(stat_errors), 64'd0);
`endif
    run_txn(1'b0, 16'h6001, 64'd0, 5'd21, 2);
    run_txn(1'b0, 16'hA000, 64'd0, 5'd22, 0);
    idle_cycle();
`ifdef CARDINAL_LSU_STATS_EN
    chk("final_stat_stall", 64'(stat_stall_cycles), 64'(exp_stall_cnt));
    chk("final_stat_errors", 64'(stat_errors), 64'(exp_err_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
